key_blink_ctrl: RTL and testbench
=================================

KEY_BLINK_CTRL -- requirements
Module: key_blink_ctrl

Interface
REQ-001 SHALL have parameter F_CLK, default 50_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter N_CH, default 4 (range 1..8), number of independent LED channels.
REQ-003 SHALL have parameters P_MIN 50, P_MAX 1000, P_STEP 50: half-period limits and step, in ms (P_MAX <= 9999).
REQ-004 SHALL have parameters DEB_MS 20, REP_DLY_MS 500, REP_RATE_MS 100: debounce time, auto-repeat delay and auto-repeat rate, in ms.
REQ-005 SHALL have port clk, input, 1, single system clock; the block uses one clock, and all internal rates are clock enables, never derived clocks.
REQ-006 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have port key, input, 4, active-low raw buttons: [0] up, [1] down, [2] next channel, [3] mode.
REQ-008 SHALL have port led, output, N_CH, per-channel LED drive, active-high.
REQ-009 SHALL have port cs, output, 8, digit select, active-low one-hot.
REQ-010 SHALL have port seg, output, 8, segments a..g on [6:0] and dp on [7], active-low.

Function
REQ-011 SHALL generate a one-cycle ms_tick every F_CLK/1000 clk cycles; all ms timing counts ms_tick.
REQ-012 SHALL debounce each key: a level is accepted only after it is stable for DEB_MS consecutive ms_ticks. Press = accepted high-to-low transition.
REQ-013 SHALL hold per channel: period (P_MIN..P_MAX) and mode (OFF=0, ON=1, BLINK=2). It SHALL also hold sel, the currently selected channel.
REQ-014 Up press SHALL set period[sel] = min(period+P_STEP, P_MAX). Down press SHALL set period[sel] = max(period-P_STEP, P_MIN). Comparisons SHALL be computed at a width that cannot wrap.
REQ-015 Auto-repeat: while up or down is held, the block SHALL issue one further step REP_DLY_MS after the press, then one step every REP_RATE_MS until release.
REQ-016 While up and down are both accepted-low, the block SHALL make no period change and SHALL suspend auto-repeat. Repeat resumes with a fresh delay if only one key remains held.
REQ-017 Next press SHALL advance sel by 1, wrapping from N_CH-1 to 0. Mode press SHALL cycle mode[sel] OFF->ON->BLINK->OFF.
REQ-018 In BLINK mode, each channel SHALL count ms_ticks and toggle its phase when count == period-1, then clear the count.
REQ-019 Any period change or mode change on a channel SHALL clear that channel's count and phase in the same cycle.
REQ-020 led[i] SHALL be 0 in OFF, 1 in ON, and phase in BLINK. Outputs SHALL be registered.
REQ-021 Display SHALL advance the digit pointer 0..7 (wrapping) on each ms_tick. cs SHALL be low only at the pointer position. seg SHALL be updated in the same cycle as cs.
REQ-022 Digit content:
- d0 = sel with dp lit
- d1 = mode[sel] (0/1/2)
- d2, d3 = blank (all segments off)
- d4..d7 = period[sel] in decimal, thousands..units, leading zeros shown

Reset
REQ-023 On rst_n low, the block SHALL asynchronously set: every period = P_MAX, every mode = BLINK, count = 0, phase = 0, sel = 0, led = 0, cs = 8'hFF, seg = 8'hFF, digit pointer = 0, debouncers accepted-high, repeat timers cleared.
REQ-024 Reset asserted mid-hold or mid-repeat SHALL abort the operation. After release, a still-held key SHALL NOT register a press until it is released and pressed again.

Structure
REQ-025 A shared package key_blink_pkg SHALL hold the mode enum, the key index constants and the 7-segment encode table (0-9, blank).
REQ-026 There SHALL be one sub-module, key_debounce (clk, rst_n, ms_tick, key_n, level, press), instantiated 4 times via generate.

Verification
REQ-027 Bench SHALL use F_CLK=10_000 (ms_tick every 10 clk), DEB_MS=2, REP_DLY_MS=5, REP_RATE_MS=2. It SHALL cover:
- Reset, then observe ch0 -> led[0] toggles every 1000 ms_ticks; display reads 0. 2 _ _ 1 0 0 0.
- 3 short down presses -> period[0]=850; toggle interval 850 ms_ticks; d4..d7 = 0 8 5 0.
- Hold down for 60 ms -> period saturates at 50 with no underflow. Then up+down held together -> period stays 50.
- Next pressed N_CH times -> sel wraps back to 0. Mode on ch1 twice (BLINK->OFF->ON) -> led[1]=1 steady and other channels unaffected.
- Key bounce of 1-ms glitches -> no press registered. Key held through rst_n pulse -> no press until re-pressed.
- cs sequence FE, FD, FB, ... 7F repeats, one step per ms_tick, with exactly one bit low at all times after the first tick.

Source files
------------

// File: rtl/key_blink_pkg.sv
// Shared types and constants for the key-driven LED blink controller:
// channel modes, key bit positions and the active-low 7-segment table.
package key_blink_pkg;

  typedef enum logic [1:0] {
    MODE_OFF   = 2'd0,
    MODE_ON    = 2'd1,
    MODE_BLINK = 2'd2
  } mode_e;

  localparam int K_UP   = 0;
  localparam int K_DN   = 1;
  localparam int K_NEXT = 2;
  localparam int K_MODE = 3;

  localparam logic [3:0] DIG_BLANK = 4'd10;

  // Segment a is bit 0, g is bit 6; a 0 lights the segment.
  function automatic logic [6:0] seg7_enc(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Debounces one active-low key on the 1 ms tick and emits a one-cycle
// press pulse on each accepted high-to-low transition.
module key_debounce #(
  parameter int DEB_MS = 20
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ms_tick,
  input  logic key_n,
  output logic level,
  output logic press
);

  logic [1:0]  r_sync;
  logic [15:0] r_cnt;
  logic        r_arm;
  logic        r_level;
  logic        r_press;
  logic        w_raw;
  logic        w_target;

  assign w_raw = r_sync[1];
  // Until a released key has been seen after reset, only "high" is confirmed,
  // so a key held through reset never produces a press.
  assign w_target = r_arm ? ~r_level : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= 2'b11;
      r_cnt   <= '0;
      r_arm   <= 1'b0;
      r_level <= 1'b1;
      r_press <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_press <= 1'b0;
      if (w_raw != w_target) begin
        r_cnt <= '0;
      end else if (ms_tick) begin
        if (r_cnt == 16'(DEB_MS - 1)) begin
          r_cnt <= '0;
          if (!r_arm) begin
            r_arm <= 1'b1;
          end else begin
            r_level <= w_raw;
            r_press <= ~w_raw;
          end
        end else begin
          r_cnt <= r_cnt + 16'd1;
        end
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/key_blink_ctrl.sv
// Four-key controller for N_CH blinking LEDs with per-channel period/mode,
// auto-repeat on up/down, and an 8-digit multiplexed status display.
module key_blink_ctrl
  import key_blink_pkg::*;
#(
  parameter int F_CLK       = 50_000_000,
  parameter int N_CH        = 4,
  parameter int P_MIN       = 50,
  parameter int P_MAX       = 1000,
  parameter int P_STEP      = 50,
  parameter int DEB_MS      = 20,
  parameter int REP_DLY_MS  = 500,
  parameter int REP_RATE_MS = 100
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      key,
  output logic [N_CH-1:0] led,
  output logic [7:0]      cs,
  output logic [7:0]      seg
);

  localparam int TICK_DIV = F_CLK / 1000;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW       = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic [TW-1:0]   r_tick_cnt;
  logic            r_ms_tick;
  logic [3:0]      w_lvl;
  logic [3:0]      w_prs;
  logic [3:0]      w_act;
  logic            w_up_held;
  logic            w_dn_held;
  logic            w_single;
  logic [15:0]     r_rep_cnt;
  logic            r_rep_first;
  logic            r_single_q;
  logic            w_rep_step;
  logic            w_inc;
  logic            w_dec;
  logic [13:0]     r_period [N_CH];
  mode_e           r_mode   [N_CH];
  logic [13:0]     r_cnt    [N_CH];
  logic [N_CH-1:0] r_phase;
  logic [N_CH-1:0] r_led;
  logic [SW-1:0]   r_sel;
  logic [13:0]     w_per_sel;
  logic [15:0]     w_sum;
  logic [13:0]     w_per_up;
  logic [13:0]     w_per_dn;
  logic [13:0]     w_per_new;
  logic            w_per_chg;
  logic            w_mode_chg;
  mode_e           w_mode_next;
  logic [2:0]      r_dig;
  logic [7:0]      r_cs;
  logic [7:0]      r_seg;
  logic [7:0]      w_dig_seg;
  logic [3:0]      w_d_th;
  logic [3:0]      w_d_hu;
  logic [3:0]      w_d_te;
  logic [3:0]      w_d_un;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_ms_tick  <= 1'b0;
    end else if (r_tick_cnt == TW'(TICK_DIV - 1)) begin
      r_tick_cnt <= '0;
      r_ms_tick  <= 1'b1;
    end else begin
      r_tick_cnt <= r_tick_cnt + 1'b1;
      r_ms_tick  <= 1'b0;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_deb
    key_debounce #(.DEB_MS(DEB_MS)) u_deb (
      .clk     (clk),
      .rst_n   (rst_n),
      .ms_tick (r_ms_tick),
      .key_n   (key[g]),
      .level   (w_lvl[g]),
      .press   (w_prs[g])
    );
  end

  assign w_act     = w_prs & ~w_lvl;
  assign w_up_held = ~w_lvl[K_UP];
  assign w_dn_held = ~w_lvl[K_DN];
  assign w_single  = w_up_held ^ w_dn_held;

  // Repeat timer restarts whenever exactly one of up/down becomes the sole held key.
  assign w_rep_step = r_ms_tick && w_single && r_single_q &&
                      (r_rep_first ? (r_rep_cnt == 16'(REP_DLY_MS - 1))
                                   : (r_rep_cnt == 16'(REP_RATE_MS - 1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_single_q  <= 1'b0;
      r_rep_cnt   <= '0;
      r_rep_first <= 1'b1;
    end else begin
      r_single_q <= w_single;
      if (!w_single || !r_single_q) begin
        r_rep_cnt   <= '0;
        r_rep_first <= 1'b1;
      end else if (r_ms_tick) begin
        if (w_rep_step) begin
          r_rep_cnt   <= '0;
          r_rep_first <= 1'b0;
        end else begin
          r_rep_cnt <= r_rep_cnt + 16'd1;
        end
      end
    end
  end

  assign w_inc = (w_act[K_UP] & ~w_dn_held) | (w_rep_step & w_up_held);
  assign w_dec = (w_act[K_DN] & ~w_up_held) | (w_rep_step & w_dn_held);

  assign w_per_sel  = r_period[r_sel];
  assign w_sum      = 16'(w_per_sel) + 16'(P_STEP);
  assign w_per_up   = (w_sum > 16'(P_MAX)) ? 14'(P_MAX) : w_sum[13:0];
  assign w_per_dn   = (16'(w_per_sel) < 16'(P_MIN + P_STEP)) ? 14'(P_MIN)
                                                              : w_per_sel - 14'(P_STEP);
  assign w_per_new  = w_inc ? w_per_up : w_per_dn;
  assign w_per_chg  = (w_inc | w_dec) && (w_per_new != w_per_sel);
  assign w_mode_chg = w_act[K_MODE];

  always_comb begin
    w_mode_next = MODE_OFF;
    case (r_mode[r_sel])
      MODE_OFF: w_mode_next = MODE_ON;
      MODE_ON:  w_mode_next = MODE_BLINK;
      default:  w_mode_next = MODE_OFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_CH; i++) begin
        r_period[i] <= 14'(P_MAX);
        r_mode[i]   <= MODE_BLINK;
        r_cnt[i]    <= '0;
      end
      r_phase <= '0;
      r_led   <= '0;
      r_sel   <= '0;
    end else begin
      if (w_act[K_NEXT])
        r_sel <= (r_sel == SW'(N_CH - 1)) ? '0 : r_sel + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        if ((SW'(i) == r_sel) && (w_per_chg || w_mode_chg)) begin
          if (w_per_chg)  r_period[i] <= w_per_new;
          if (w_mode_chg) r_mode[i]   <= w_mode_next;
          r_cnt[i]   <= '0;
          r_phase[i] <= 1'b0;
        end else if (r_mode[i] != MODE_BLINK) begin
          r_cnt[i]   <= '0;
          r_phase[i] <= 1'b0;
        end else if (r_ms_tick) begin
          if (r_cnt[i] == r_period[i] - 14'd1) begin
            r_cnt[i]   <= '0;
            r_phase[i] <= ~r_phase[i];
          end else begin
            r_cnt[i] <= r_cnt[i] + 14'd1;
          end
        end
        case (r_mode[i])
          MODE_OFF: r_led[i] <= 1'b0;
          MODE_ON:  r_led[i] <= 1'b1;
          default:  r_led[i] <= r_phase[i];
        endcase
      end
    end
  end

  assign w_d_th = 4'(w_per_sel / 14'd1000);
  assign w_d_hu = 4'((w_per_sel / 14'd100) % 14'd10);
  assign w_d_te = 4'((w_per_sel / 14'd10) % 14'd10);
  assign w_d_un = 4'(w_per_sel % 14'd10);

  always_comb begin
    w_dig_seg = {1'b1, seg7_enc(DIG_BLANK)};
    case (r_dig)
      3'd0:    w_dig_seg = {1'b0, seg7_enc(4'(r_sel))};
      3'd1:    w_dig_seg = {1'b1, seg7_enc(4'(r_mode[r_sel]))};
      3'd4:    w_dig_seg = {1'b1, seg7_enc(w_d_th)};
      3'd5:    w_dig_seg = {1'b1, seg7_enc(w_d_hu)};
      3'd6:    w_dig_seg = {1'b1, seg7_enc(w_d_te)};
      3'd7:    w_dig_seg = {1'b1, seg7_enc(w_d_un)};
      default: w_dig_seg = {1'b1, seg7_enc(DIG_BLANK)};
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dig <= '0;
      r_cs  <= 8'hFF;
      r_seg <= 8'hFF;
    end else if (r_ms_tick) begin
      r_cs  <= ~(8'h01 << r_dig);
      r_seg <= w_dig_seg;
      r_dig <= r_dig + 3'd1;
    end
  end

  assign led = r_led;
  assign cs  = r_cs;
  assign seg = r_seg;

endmodule

// File: tb/tb_key_blink_ctrl.sv
// Scoreboard bench for key_blink_ctrl: stimulus queues expected display
// digits, LED levels and blink intervals; a monitor checks them as they appear.
module tb_key_blink_ctrl;

  localparam int N_CH   = 4;
  localparam int K_UP   = 0;
  localparam int K_DN   = 1;
  localparam int K_NEXT = 2;
  localparam int K_MODE = 3;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [3:0]      key = 4'hF;
  logic [N_CH-1:0] led;
  logic [7:0]      cs;
  logic [7:0]      seg;

  key_blink_ctrl #(
    .F_CLK(10_000), .N_CH(N_CH), .P_MIN(50), .P_MAX(1000), .P_STEP(50),
    .DEB_MS(2), .REP_DLY_MS(5), .REP_RATE_MS(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key(key), .led(led), .cs(cs), .seg(seg)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit              is_led;
    logic [7:0]      cs;
    logic [7:0]      seg;
    logic [N_CH-1:0] led;
    logic [N_CH-1:0] mask;
    string           name;
  } exp_t;

  exp_t q_exp[$];
  int   q_iv[$];

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  // Monitor: display strobe on every cs change, blink interval on every led[0] edge.
  initial begin : monitor
    logic [7:0]      prev_cs;
    logic [7:0]      exp_cs;
    logic            prev_l0;
    int              ptr;
    int              last_cs;
    int              last_edge;
    bit              seen;
    exp_t            e;
    prev_cs = 8'hFF; prev_l0 = 1'b0; ptr = 0; last_cs = 0; last_edge = 0; seen = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_cs = 8'hFF; prev_l0 = 1'b0; ptr = 0; seen = 0; last_edge = cyc;
        continue;
      end
      if (cs !== prev_cs) begin
        exp_cs = ~(8'h01 << ptr);
        check("cs_seq", cs, exp_cs);
        if (seen) check("cs_step", cyc - last_cs, 10);
        seen = 1; last_cs = cyc; ptr = (ptr + 1) % 8; prev_cs = cs;
        if (q_exp.size() > 0) begin
          e = q_exp[0];
          if (e.is_led) begin
            check(e.name, led & e.mask, e.led);
            void'(q_exp.pop_front());
          end else if (e.cs == cs) begin
            check(e.name, seg, e.seg);
            void'(q_exp.pop_front());
          end
        end
      end
      if (led[0] !== prev_l0) begin
        if (q_iv.size() > 0) check("blink_iv", cyc - last_edge, q_iv.pop_front());
        last_edge = cyc;
        prev_l0 = led[0];
      end
    end
  end

  task automatic ms(input int n);
    repeat (n * 10) @(posedge clk);
  endtask

  task automatic tap(input int k);
    key[k] = 1'b0;
    ms(3);
    key[k] = 1'b1;
    ms(4);
  endtask

  task automatic wait_q(input string tag);
    int n = 0;
    while (q_exp.size() > 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q_exp.size() > 0) begin
      check({tag, "_timeout"}, q_exp.size(), 0);
      q_exp.delete();
    end
  endtask

  task automatic expect_disp(input string tag, input logic [63:0] d);
    exp_t e;
    for (int k = 0; k < 8; k++) begin
      e.is_led = 1'b0;
      e.cs     = ~(8'h01 << k);
      e.seg    = d[63 - 8*k -: 8];
      e.led    = '0;
      e.mask   = '0;
      e.name   = $sformatf("%s_d%0d", tag, k);
      q_exp.push_back(e);
    end
    wait_q(tag);
  endtask

  task automatic expect_led(input string tag, input logic [N_CH-1:0] v, input logic [N_CH-1:0] m);
    exp_t e;
    e.is_led = 1'b1; e.cs = 8'hFF; e.seg = 8'hFF; e.led = v; e.mask = m; e.name = tag;
    q_exp.push_back(e);
    wait_q(tag);
  endtask

  task automatic expect_iv(input string tag, input int iv, input int maxcyc);
    logic p;
    int   n;
    @(negedge clk);
    p = led[0];
    n = 0;
    while (led[0] === p && n < maxcyc) begin
      @(negedge clk);
      n++;
    end
    if (n >= maxcyc) check({tag, "_edge"}, led[0], ~p);
    @(posedge clk);
    q_iv.push_back(iv);
    n = 0;
    while (q_iv.size() > 0 && n < maxcyc) begin
      @(negedge clk);
      n++;
    end
    if (q_iv.size() > 0) begin
      check({tag, "_timeout"}, q_iv.size(), 0);
      q_iv.delete();
    end
  endtask

  initial begin : watchdog
    repeat (150000) @(posedge clk);
    $display("FAIL watchdog: got %0d cycles required completion earlier", cyc);
    $fatal(1);
  end

  initial begin : stim
    repeat (5) @(posedge clk);
    @(negedge clk);
    check("rst_led", led, 0);
    check("rst_cs", cs, 8'hFF);
    check("rst_seg", seg, 8'hFF);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pre_tick_cs", cs, 8'hFF);
    ms(5);

    expect_disp("init", {8'h40, 8'hA4, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0});
    expect_iv("blink1000", 10000, 12000);

    repeat (3) tap(K_DN);
    expect_iv("blink850", 8500, 10000);
    expect_disp("p850", {8'h40, 8'hA4, 8'hFF, 8'hFF, 8'hC0, 8'h80, 8'h92, 8'hC0});

    key[K_DN] = 1'b0;
    ms(60);
    key[K_DN] = 1'b1;
    ms(5);
    expect_disp("p50", {8'h40, 8'hA4, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'h92, 8'hC0});

    key[K_DN] = 1'b0;
    ms(5);
    key[K_UP] = 1'b0;
    ms(20);
    key[K_UP] = 1'b1;
    key[K_DN] = 1'b1;
    ms(5);
    expect_disp("both", {8'h40, 8'hA4, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'h92, 8'hC0});
    expect_iv("blink50", 500, 1500);

    tap(K_NEXT);
    expect_disp("sel1", {8'h79, 8'hA4, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0});
    repeat (3) tap(K_NEXT);
    expect_disp("wrap", {8'h40, 8'hA4, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'h92, 8'hC0});

    tap(K_NEXT);
    tap(K_MODE);
    expect_led("ch1_off", 4'b0000, 4'b0010);
    tap(K_MODE);
    expect_led("ch1_on", 4'b0010, 4'b0010);
    expect_disp("ch1", {8'h79, 8'hF9, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0});
    ms(50);
    expect_led("ch1_steady", 4'b0010, 4'b0010);
    expect_iv("ch0_still50", 500, 1500);
    tap(K_NEXT);
    expect_disp("ch2", {8'h24, 8'hA4, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0});
    tap(K_NEXT);
    tap(K_NEXT);

    repeat (5) begin
      key[K_NEXT] = 1'b0;
      repeat (9) @(posedge clk);
      key[K_NEXT] = 1'b1;
      repeat (10) @(posedge clk);
    end
    ms(5);
    expect_disp("bounce", {8'h40, 8'hA4, 8'hFF, 8'hFF, 8'hC0, 8'hC0, 8'h92, 8'hC0});

    key[K_NEXT] = 1'b0;
    ms(5);
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    rst_n = 1'b1;
    ms(20);
    expect_led("rst_leds", 4'b0000, 4'b1111);
    expect_disp("rst_held", {8'h40, 8'hA4, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0});
    key[K_NEXT] = 1'b1;
    ms(5);
    tap(K_NEXT);
    expect_disp("repress", {8'h79, 8'hA4, 8'hFF, 8'hFF, 8'hF9, 8'hC0, 8'hC0, 8'hC0});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
